i2s_transmitter: RTL and testbench
==================================

Name: i2s_transmitter

Overview:
- Consumes the signed mono sample produced once per frame by the oscillator mixer.
- Serialises it MSB-first as standard Philips I2S, with the same sample on the left and right channels, for the external audio DAC.
- Generates bclk and lrclk from the system clock.
- Has a one-deep holding register with a valid/ready handshake, and counts underruns.

Parameters:
- WIDTH, 24: sample width in bits; must match the mixer output width; WIDTH <= FRAME_BITS-1.
- FRAME_BITS, 32: bclk slots per channel; a frame is 2*FRAME_BITS slots.
- BCLK_DIV, 4: system clocks per bclk half-period (>=1); bclk period = 2*BCLK_DIV clk.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- sample_in  in  WIDTH (signed)  mixed sample from the mixer.
- sample_valid  in  1  sample_in is valid this cycle.
- sample_ready  out  1  transmitter accepts a sample this cycle.
- sample_req  out  1  one-clk pulse at every frame load; the mixer uses it as its frame strobe.
- bclk  out  1  I2S bit clock.
- lrclk  out  1  I2S word select; 0 = left, 1 = right.
- sdata  out  1  I2S serial data.
- underrun  out  1  one-clk pulse when a frame loads with no sample available.
- underrun_count  out  16  saturating count of underruns.

Behaviour:
- **Reset** (rst high at a posedge): all of the following are cleared.
  - Outputs: bclk=0, lrclk=0, sdata=0, sample_req=0, underrun=0, underrun_count=0, sample_ready=0.
  - Internal state: divider=0, slot=0, holding register empty, transmit word=0.
  - rst asserted mid-frame aborts the frame immediately; no partial word resumes.
- **Ready:** sample_ready = !rst_q && (!hold_full || load_now), where load_now is the frame-load event in that cycle.
  - Accept happens on valid && ready.
- **Divider:** counts 0..BCLK_DIV-1; at BCLK_DIV-1 it wraps and bclk toggles.
  - A toggle 0->1 is a rising event.
  - A toggle 1->0 is a falling event; all slot, lrclk and sdata updates happen only on falling events.
- **Slot counter:** on each falling event, slot counts 0..2*FRAME_BITS-1 and wraps to 0.
  - The wrap to 0 is the frame-load event (load_now).
  - Let c = slot mod FRAME_BITS.
  - lrclk = (slot >= FRAME_BITS).
  - sdata = word[WIDTH-c] for 1 <= c <= WIDTH, else 0 (MSB one bclk after the lrclk edge; zero padding).
  - The same word is sent on both channels.
  - sdata and lrclk are registered and change in the same clk as the bclk falling edge; the DAC samples on the rising edge.
- **Frame load** (load_now), priority order:
  1. hold_full: word <= holding; hold_full <= 0.
  2. Else if sample_valid: bypass; word <= sample_in; the sample is accepted and nothing is stored.
  3. Else: word <= 0; underrun pulses one clk; underrun_count increments, saturating at 16'hFFFF.
  - In all three cases sample_req pulses one clk.
- **Accept outside load:** holding <= sample_in; hold_full <= 1.
- **Accept in a load cycle with hold_full=1:** the held sample goes to word, and the new sample refills holding (hold_full stays 1).
- **After reset:** the first frame sends word=0 with no load event, so no underrun and no sample_req.
  - The first load occurs at the first slot wrap, 2*FRAME_BITS bclk periods after reset release.
- **Holding behaviour:** a sample is never overwritten while held; valid with ready=0 is stalled by the producer.
- **Latency:** a sample accepted before load k is first driven (MSB) one bclk after load k.

Test Plan:
- Reset/idle (WIDTH=24, FRAME_BITS=32, BCLK_DIV=2), no input:
  - bclk period 4 clk; lrclk toggles every 128 clk.
  - sdata=0 throughout.
  - First sample_req at clk 256 after reset release, with underrun=1 and underrun_count=1.
- Single sample 24'h800001 presented before the first load:
  - Left and right slots 1..24 each carry 1,0x22,1 MSB-first; slots 0 and 25..31 are 0.
  - underrun_count stays 0.
- Back-to-back samples A=24'h123456, B=24'hFEDCBA:
  - A is accepted and held; sample_ready=0 until load.
  - B is accepted in the load cycle.
  - Consecutive frames carry A then B; no underrun.
- Bypass: hold empty, sample_valid asserted only in the load_now cycle with 24'h7FFFFF:
  - sample_ready=1; that frame carries 7FFFFF; underrun=0.
- Underrun saturation: preload underrun_count near max via force, or run 65536 empty frames:
  - Count stops at 16'hFFFF; underrun still pulses each empty frame.
- Mid-frame reset at slot 40:
  - Next clk: all outputs 0, sample_ready=0, hold cleared.
  - Timing restarts exactly as in the reset/idle case.

Source files
------------

// File: rtl/i2s_transmitter.sv
// i2s_transmitter
// Serialises one mono sample per frame as Philips I2S (same word on the left
// and right channels). bclk and lrclk are derived from clk by a divider; a
// one-deep holding register with a valid/ready handshake decouples the mixer
// from the frame timing, and frames loaded with nothing available count as
// underruns.
module i2s_transmitter #(
    parameter int WIDTH      = 24,   // sample width, WIDTH <= FRAME_BITS-1
    parameter int FRAME_BITS = 32,   // bclk slots per channel
    parameter int BCLK_DIV   = 4     // clk cycles per bclk half-period, >= 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sample_in,      // two's-complement sample from the mixer
    input  logic             sample_valid,
    output logic             sample_ready,
    output logic             sample_req,
    output logic             bclk,
    output logic             lrclk,
    output logic             sdata,
    output logic             underrun,
    output logic [15:0]      underrun_count
);

    localparam int SLOTS  = 2 * FRAME_BITS;
    localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int DIV_W  = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int C_W    = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(BCLK_DIV - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOTS - 1);
    localparam logic [SLOT_W-1:0] HALF      = SLOT_W'(FRAME_BITS);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic              rst_q_reg;
    logic [DIV_W-1:0]  div_reg;
    logic              bclk_reg;
    logic [SLOT_W-1:0] slot_reg;
    logic              lrclk_reg;
    logic              sdata_reg;
    logic [WIDTH-1:0]  word_reg;
    logic [WIDTH-1:0]  hold_reg;
    logic              hold_full_reg;
    logic              sample_req_reg;
    logic              underrun_reg;
    logic [15:0]       underrun_count_reg;

    // ------------------------------------------------------------------
    // Timing events
    // ------------------------------------------------------------------
    logic              div_wrap;
    logic              fall_evt;
    logic              slot_wrap;
    logic              load_now;
    logic [SLOT_W-1:0] slot_next;
    logic              upper_half;
    logic [C_W-1:0]    chan_bit;
    logic [FRAME_BITS-1:0] slot_bits;
    logic              sdata_next;
    logic              ready;
    logic              accept;

    assign div_wrap  = (div_reg == DIV_LAST);
    // bclk is high when the divider wraps, so this wrap drives it low.
    assign fall_evt  = div_wrap && bclk_reg;
    assign slot_wrap = (slot_reg == SLOT_LAST);
    // The frame boundary is the falling edge on which the slot counter wraps.
    assign load_now  = fall_evt && slot_wrap;

    assign slot_next  = slot_wrap ? '0 : slot_reg + SLOT_W'(1);
    assign upper_half = (slot_next >= HALF);
    // Bit position within the current channel for the slot about to start.
    assign chan_bit   = C_W'(upper_half ? (slot_next - HALF) : slot_next);

    // Per-slot data map: slot 0 is the one-bclk I2S delay, slots 1..WIDTH carry
    // the word MSB first, the remaining slots are zero padding.
    genvar gi;
    generate
        for (gi = 0; gi < FRAME_BITS; gi = gi + 1) begin : g_slot
            if ((gi >= 1) && (gi <= WIDTH)) begin : g_data
                assign slot_bits[gi] = word_reg[WIDTH-gi];
            end else begin : g_pad
                assign slot_bits[gi] = 1'b0;
            end
        end
    endgenerate

    // At a load the new slot is 0, which is padding, so using the outgoing
    // word here is harmless.
    assign sdata_next = slot_bits[chan_bit];

    // A sample can be taken while the holding register is empty, or in the
    // load cycle, when the held sample moves into the transmit word.
    assign ready  = !rst_q_reg && (!hold_full_reg || load_now);
    assign accept = sample_valid && ready;

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------

    // Delayed reset keeps the handshake closed for the cycle after release.
    always_ff @(posedge clk) begin
        rst_q_reg <= rst;
    end

    // Clock divider producing bclk with a 2*BCLK_DIV clk period.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_reg  <= '0;
            bclk_reg <= 1'b0;
        end else if (div_wrap) begin
            div_reg  <= '0;
            bclk_reg <= !bclk_reg;
        end else begin
            div_reg  <= div_reg + DIV_W'(1);
        end
    end

    // Slot counter, word select and serial data, all advanced on bclk falls.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_reg  <= '0;
            lrclk_reg <= 1'b0;
            sdata_reg <= 1'b0;
        end else if (fall_evt) begin
            slot_reg  <= slot_next;
            lrclk_reg <= upper_half;
            sdata_reg <= sdata_next;
        end
    end

    // Holding register, transmit word, frame strobe and underrun accounting.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_reg           <= '0;
            hold_reg           <= '0;
            hold_full_reg      <= 1'b0;
            sample_req_reg     <= 1'b0;
            underrun_reg       <= 1'b0;
            underrun_count_reg <= '0;
        end else begin
            sample_req_reg <= load_now;
            underrun_reg   <= 1'b0;
            if (load_now) begin
                if (hold_full_reg) begin
                    word_reg <= hold_reg;
                    if (accept) begin
                        // Refill behind the sample just moved out; stays full.
                        hold_reg <= sample_in;
                    end else begin
                        hold_full_reg <= 1'b0;
                    end
                end else if (accept) begin
                    // Bypass: the sample goes straight into the frame.
                    word_reg <= sample_in;
                end else begin
                    // Nothing to send: transmit silence and record it.
                    word_reg     <= '0;
                    underrun_reg <= 1'b1;
                    if (underrun_count_reg != 16'hFFFF) begin
                        underrun_count_reg <= underrun_count_reg + 16'd1;
                    end
                end
            end else if (accept) begin
                hold_reg      <= sample_in;
                hold_full_reg <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign sample_ready   = ready;
    assign sample_req     = sample_req_reg;
    assign bclk           = bclk_reg;
    assign lrclk          = lrclk_reg;
    assign sdata          = sdata_reg;
    assign underrun       = underrun_reg;
    assign underrun_count = underrun_count_reg;

endmodule

// File: tb/tb_i2s_transmitter.sv
// Bench for i2s_transmitter: independent timing model for bclk/lrclk/strobes,
// serial capture on bclk rising edges, and a scoreboard of expected frames.
module tb_i2s_transmitter;

    localparam int WIDTH      = 24;
    localparam int FRAME_BITS = 32;
    localparam int BCLK_DIV   = 2;
    localparam int BCLK_CLKS  = 2 * BCLK_DIV;
    localparam int FRAME_CLKS = 2 * FRAME_BITS * BCLK_CLKS;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] sample_in = '0;
    logic             sample_valid = 1'b0;
    logic             sample_ready;
    logic             sample_req;
    logic             bclk;
    logic             lrclk;
    logic             sdata;
    logic             underrun;
    logic [15:0]      underrun_count;

    i2s_transmitter #(
        .WIDTH(WIDTH),
        .FRAME_BITS(FRAME_BITS),
        .BCLK_DIV(BCLK_DIV)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sample_in(sample_in),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .sample_req(sample_req),
        .bclk(bclk),
        .lrclk(lrclk),
        .sdata(sdata),
        .underrun(underrun),
        .underrun_count(underrun_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // clk edges since reset release; 0 right after the last reset edge.
    int cyc = 0;
    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    typedef struct {
        logic [WIDTH-1:0] word;
        bit               urun;
    } frame_t;

    frame_t           sb[$];
    frame_t           cur;
    bit               have_cur = 1'b0;
    bit               mon_en = 1'b0;
    int               exp_count = 0;
    int               frame_no = 0;
    logic [WIDTH-1:0] lw = '0;
    logic [WIDTH-1:0] rw = '0;

    function automatic void push(input logic [WIDTH-1:0] w, input bit u);
        frame_t f;
        f.word = w;
        f.urun = u;
        sb.push_back(f);
    endfunction

    always @(negedge clk) begin : monitor
        int slot;
        int c;
        bit load;
        if (mon_en) begin
            slot = (cyc / BCLK_CLKS) % (2 * FRAME_BITS);
            c    = slot % FRAME_BITS;
            load = (cyc > 0) && (cyc % FRAME_CLKS == 0);
            if (cyc % FRAME_CLKS == 0) begin
                if (have_cur) begin
                    $display("frame %0d left=%h right=%h expect=%h", frame_no, lw, rw, cur.word);
                    chk("frame_left", lw, cur.word);
                    chk("frame_right", rw, cur.word);
                    frame_no++;
                end
                chk("sb_level", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    cur = sb.pop_front();
                    have_cur = 1'b1;
                end else begin
                    have_cur = 1'b0;
                end
                lw = '0;
                rw = '0;
                if (load && have_cur && cur.urun && exp_count != 16'hFFFF) exp_count++;
                chk("underrun_count", underrun_count, exp_count);
            end
            chk("bclk", bclk, (cyc / BCLK_DIV) % 2);
            chk("lrclk", lrclk, slot >= FRAME_BITS);
            chk("sample_req", sample_req, load);
            chk("underrun", underrun, load && have_cur && cur.urun);
            // bclk rising edge: the DAC sampling point
            if (cyc % BCLK_CLKS == BCLK_DIV) begin
                if (c >= 1 && c <= WIDTH) begin
                    if (slot < FRAME_BITS) lw = {lw[WIDTH-2:0], sdata};
                    else                   rw = {rw[WIDTH-2:0], sdata};
                end else begin
                    chk("pad_bit", sdata, 0);
                end
            end
        end
    end

    task automatic do_reset();
        mon_en = 1'b0;
        rst = 1'b1;
        sample_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_bclk", bclk, 0);
        chk("rst_lrclk", lrclk, 0);
        chk("rst_sdata", sdata, 0);
        chk("rst_sample_req", sample_req, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_underrun_count", underrun_count, 0);
        chk("rst_sample_ready", sample_ready, 0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        sb.delete();
        exp_count = 0;
        have_cur = 1'b0;
        frame_no = 0;
        mon_en = 1'b1;
    endtask

    task automatic wait_cyc(input int target);
        for (int i = 0; i < 100000 && cyc < target; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send(input logic [WIDTH-1:0] s, output bit ok, output int acc_cyc);
        ok = 1'b0;
        acc_cyc = -1;
        sample_in = s;
        sample_valid = 1'b1;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            if (sample_ready) begin
                ok = 1'b1;
                acc_cyc = cyc;
            end
            @(posedge clk);
            #2;
        end
        sample_valid = 1'b0;
    endtask

    initial begin : stim
        bit ok;
        int acc;

        // Idle: silence, first load at 256 clk is an underrun.
        do_reset();
        push('0, 1'b0); push('0, 1'b1); push('0, 1'b1);
        wait_cyc(1);
        @(negedge clk);
        chk("ready_after_release", sample_ready, 1);
        wait_cyc(FRAME_CLKS * 2 + 8);

        // Single sample before the first load.
        do_reset();
        push('0, 1'b0); push(24'h800001, 1'b0); push('0, 1'b1);
        send(24'h800001, ok, acc);
        chk("single_accept", ok, 1);
        wait_cyc(FRAME_CLKS * 2 + 8);

        // Back-to-back: A held, B taken in the load cycle.
        do_reset();
        push('0, 1'b0); push(24'h123456, 1'b0); push(24'hFEDCBA, 1'b0); push('0, 1'b1);
        send(24'h123456, ok, acc);
        chk("a_accept", ok, 1);
        wait_cyc(100);
        @(negedge clk);
        chk("ready_while_held", sample_ready, 0);
        send(24'hFEDCBA, ok, acc);
        chk("b_accept", ok, 1);
        chk("b_accept_cyc", acc, FRAME_CLKS - 1);
        wait_cyc(FRAME_CLKS * 3 + 8);

        // Bypass: valid only in the load cycle with the hold empty.
        do_reset();
        push('0, 1'b0); push(24'h7FFFFF, 1'b0); push('0, 1'b1);
        wait_cyc(FRAME_CLKS - 1);
        sample_in = 24'h7FFFFF;
        sample_valid = 1'b1;
        @(negedge clk);
        chk("bypass_ready", sample_ready, 1);
        @(posedge clk);
        #2;
        sample_valid = 1'b0;
        wait_cyc(FRAME_CLKS * 2 + 8);

        // Saturation: preload the counter just below full.
        do_reset();
        push('0, 1'b0); push('0, 1'b1); push('0, 1'b1); push('0, 1'b1);
        wait_cyc(FRAME_CLKS + 44);
        force dut.underrun_count_reg = 16'hFFFE;
        exp_count = 16'hFFFE;
        @(posedge clk);
        #1;
        release dut.underrun_count_reg;
        wait_cyc(FRAME_CLKS * 3 + 8);

        // Mid-frame reset at slot 40 of frame 1 with a sample held.
        do_reset();
        push('0, 1'b0); push('0, 1'b1); push('0, 1'b1);
        wait_cyc(FRAME_CLKS + 44);
        send(24'h55AA33, ok, acc);
        chk("held_accept", ok, 1);
        wait_cyc(FRAME_CLKS + 40 * BCLK_CLKS + BCLK_DIV);
        do_reset();
        push('0, 1'b0); push('0, 1'b1); push('0, 1'b1);
        wait_cyc(FRAME_CLKS * 2 + 8);

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
